// File: rtl/wavetable_interp_ctrl_if.sv
// Phase-request, wavetable-read and sample-output signals of the wavetable
// interpolation controller, bundled so the controller and its environment share one port.
interface wavetable_interp_ctrl_if #(
    parameter int INPUT_BITS      = 16,
    parameter int RATIO_FRAC_BITS = 8,
    parameter int ADDR_BITS       = 8
);
    logic                                 in_valid;
    logic                                 in_ready;
    logic [ADDR_BITS+RATIO_FRAC_BITS-1:0] in_phase;
    logic                                 mem_rd;
    logic [ADDR_BITS-1:0]                 mem_addr;
    logic [INPUT_BITS-1:0]                mem_rdata;
    logic                                 out_valid;
    logic                                 out_ready;
    logic [INPUT_BITS-1:0]                out_sample;
    logic                                 busy;

    modport slave (
        input  in_valid, in_phase, mem_rdata, out_ready,
        output in_ready, mem_rd, mem_addr, out_valid, out_sample, busy
    );

    modport master (
        output in_valid, in_phase, mem_rdata, out_ready,
        input  in_ready, mem_rd, mem_addr, out_valid, out_sample, busy
    );
endinterface

// File: rtl/wavetable_interp_ctrl.sv
// Reads two adjacent wavetable samples for a phase request and emits their linear
// interpolation, one request at a time (accept -> read lo -> read hi -> compute -> hold).
module wavetable_interp_ctrl #(
    parameter int INPUT_BITS      = 16,
    parameter int RATIO_FRAC_BITS = 8,
    parameter int ADDR_BITS       = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    wavetable_interp_ctrl_if.slave bus
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] RD_LO = 3'd1;
    localparam logic [2:0] RD_HI = 3'd2;
    localparam logic [2:0] CAPT  = 3'd3;
    localparam logic [2:0] OUT   = 3'd4;

    logic [2:0]                 state_reg, state_next;
    logic [ADDR_BITS-1:0]       idx_reg;
    logic [ADDR_BITS-1:0]       idx_plus1;
    logic [RATIO_FRAC_BITS-1:0] ratio_reg;
    logic [INPUT_BITS-1:0]      lo_reg;
    logic [INPUT_BITS-1:0]      sample_reg;
    logic [INPUT_BITS-1:0]      lerp_next;
    logic                       ready_en_reg;
    logic                       accept;

    logic signed [INPUT_BITS:0]                 diff;
    logic signed [INPUT_BITS+RATIO_FRAC_BITS:0] diff_ext;
    logic signed [INPUT_BITS+RATIO_FRAC_BITS:0] ratio_ext;
    logic signed [INPUT_BITS+RATIO_FRAC_BITS:0] prod;

    // ready_en_reg keeps in_ready low until the first edge after reset release
    assign bus.in_ready   = (state_reg == IDLE) && ready_en_reg;
    assign bus.out_valid  = (state_reg == OUT);
    assign bus.busy       = (state_reg != IDLE);
    assign bus.out_sample = sample_reg;
    assign accept         = bus.in_valid && bus.in_ready;
    assign idx_plus1      = idx_reg + {{(ADDR_BITS-1){1'b0}}, 1'b1};

    // hi arrives on mem_rdata during CAPT; the product width holds |d|*ratio exactly
    always_comb begin
        diff      = $signed({1'b0, bus.mem_rdata}) - $signed({1'b0, lo_reg});
        diff_ext  = {{RATIO_FRAC_BITS{diff[INPUT_BITS]}}, diff};
        ratio_ext = {{(INPUT_BITS+1){1'b0}}, ratio_reg};
        prod      = diff_ext * ratio_ext;
        lerp_next = INPUT_BITS'(prod >>> RATIO_FRAC_BITS) + lo_reg;
    end

    always_comb begin
        bus.mem_rd   = 1'b0;
        bus.mem_addr = '0;
        case (state_reg)
            RD_LO: begin
                bus.mem_rd   = 1'b1;
                bus.mem_addr = idx_reg;
            end
            RD_HI: begin
                bus.mem_rd   = 1'b1;
                bus.mem_addr = idx_plus1;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = RD_LO;
            RD_LO:   state_next = RD_HI;
            RD_HI:   state_next = CAPT;
            CAPT:    state_next = OUT;
            OUT:     if (bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            idx_reg      <= '0;
            ratio_reg    <= '0;
            lo_reg       <= '0;
            sample_reg   <= '0;
            ready_en_reg <= 1'b0;
        end else begin
            ready_en_reg <= 1'b1;
            state_reg    <= state_next;
            if (accept) begin
                idx_reg   <= bus.in_phase[ADDR_BITS+RATIO_FRAC_BITS-1:RATIO_FRAC_BITS];
                ratio_reg <= bus.in_phase[RATIO_FRAC_BITS-1:0];
            end
            if (state_reg == RD_HI) lo_reg <= bus.mem_rdata;
            if (state_reg == CAPT) sample_reg <= lerp_next;
        end
    end
endmodule

// File: doc/wavetable_interp_ctrl.md
WAVETABLE_INTERP_CTRL -- requirements
Module: wavetable_interp_ctrl

Interface
REQ-001 Parameter INPUT_BITS, default 16: sample width, unsigned QUx.0.
REQ-002 Parameter RATIO_FRAC_BITS, default 8: fractional phase width, QU0.r interpolation ratio.
REQ-003 Parameter ADDR_BITS, default 8: wavetable address width; table depth 2^ADDR_BITS.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset, named as follows.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
REQ-005 Data ports SHALL be as follows.
- in_valid  in  1  phase request valid.
- in_ready  out  1  controller can accept a phase.
- in_phase  in  ADDR_BITS+RATIO_FRAC_BITS  upper ADDR_BITS = table index; lower RATIO_FRAC_BITS = ratio.
- mem_rd  out  1  wavetable read strobe.
- mem_addr  out  ADDR_BITS  wavetable read address.
- mem_rdata  in  INPUT_BITS  read data, valid exactly one cycle after mem_rd.
- out_valid  out  1  interpolated sample valid.
- out_ready  in  1  consumer accepts sample.
- out_sample  out  INPUT_BITS  interpolated sample.
- busy  out  1  high in every state except IDLE.

Function
REQ-006 FSM states SHALL be IDLE, RD_LO, RD_HI, CAPT and OUT.
REQ-007 in_ready SHALL be 1 only in IDLE; the handshake SHALL occur on an edge where in_valid & in_ready.
REQ-008 On the handshake, idx and ratio SHALL be latched from in_phase and the FSM SHALL go IDLE->RD_LO.
REQ-009 RD_LO SHALL drive mem_rd=1 and mem_addr=idx, then go to RD_HI.
REQ-010 RD_HI SHALL drive mem_rd=1 and mem_addr=(idx+1) mod 2^ADDR_BITS, register lo=mem_rdata, then go to CAPT.
REQ-011 CAPT SHALL drive mem_rd=0, take hi=mem_rdata, register out_sample=lerp(hi,lo,ratio), then go to OUT.
REQ-012 lerp arithmetic: d = hi-lo as signed INPUT_BITS+1; p = d*ratio as signed INPUT_BITS+RATIO_FRAC_BITS+1; q = p arithmetic-shift-right RATIO_FRAC_BITS (floor toward -inf); out_sample = (q+lo) truncated to INPUT_BITS.
REQ-013 OUT SHALL hold out_valid=1, with out_sample stable, until out_ready=1; on that edge the FSM SHALL go to IDLE.
REQ-014 Latency: out_valid SHALL first assert in the 4th cycle after the accept edge; maximum throughput is one sample per 5 cycles with out_ready tied high.
REQ-015 Index wrap: idx = 2^ADDR_BITS-1 SHALL read the hi sample from address 0.
REQ-016 ratio=0 SHALL yield out_sample=lo; both reads SHALL still be issued.
REQ-017 in_valid arriving outside IDLE SHALL be ignored (in_ready=0) and SHALL NOT alter latched idx or ratio.
REQ-018 mem_rd SHALL be 0 in IDLE, CAPT and OUT; mem_addr SHALL be don't-care when mem_rd=0.
REQ-019 busy SHALL be 1 in RD_LO, RD_HI, CAPT and OUT.

Reset
REQ-020 When rst_n=0, the FSM SHALL asynchronously enter IDLE and clear out_valid, mem_rd, mem_addr, out_sample, busy and all internal registers to 0.
REQ-021 While rst_n=0, in_ready SHALL be 0.
REQ-022 in_ready SHALL rise on the first clk edge after rst_n deasserts.
REQ-023 Reset asserted mid-transaction SHALL discard the transaction; no out_valid shall follow it.

Verification
REQ-024 Table[5]=100, table[6]=200, phase={5,0x80} -> mem reads at addr 5 then 6; out_sample=150, out_valid in 4th cycle after accept.
REQ-025 Table[5]=200, table[6]=100, ratio=0x40 -> out_sample=175; with ratio=0x80 -> 150.
REQ-026 Floor rounding: lo=10, hi=9, ratio=0x01 -> out_sample=9.
REQ-027 Wrap: idx=0xFF, table[0xFF]=0, table[0]=0xFFFF, ratio=0xFF -> reads 0xFF then 0x00; out_sample=0xFEFF.
REQ-028 Backpressure: hold out_ready=0 for 10 cycles while toggling in_valid and in_phase -> out_sample constant, in_ready=0, no mem_rd; releasing out_ready -> IDLE next cycle.
REQ-029 Reset in RD_HI -> all outputs 0 immediately; no out_valid; in_ready=1 one edge after rst_n rises.
